// File: rtl/imem_loader.sv
// imem_loader: receives a program image over a byte link, assembles big-endian
// 32-bit words and writes them into instruction memory. Keeps the core held
// until the whole image has arrived and its XOR checksum matches.
//
// Stream: CNT_HI, CNT_LO (word count N), 4*N data bytes MSB first, CHK byte.
// CHK is the XOR of CNT_HI, CNT_LO and every data byte.
//
// Byte handshake: a byte moves on a rising Clk edge where ByteValid and
// ByteReady are both 1. ByteReady depends only on the current state, so the
// host may hold ByteValid high continuously; ByteIn is ignored unless accepted.
module imem_loader #(
    parameter int                ADDR_W    = 32,
    parameter int                MAX_WORDS = 256,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Start,
    input  logic [7:0]        ByteIn,
    input  logic              ByteValid,
    output logic              ByteReady,
    output logic [31:0]       WriteData,
    output logic [ADDR_W-1:0] WriteAddress,
    output logic              WriteEnable,
    output logic              CoreHold,
    output logic              Done,
    output logic              Error,
    output logic [2:0]        DbgState
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HDR_HI = 3'd1,
        S_HDR_LO = 3'd2,
        S_DATA   = 3'd3,
        S_CHK    = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_e;

    localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

    state_e              state_q, state_d;
    logic [15:0]         cnt_q, cnt_d;      // word count N from the header
    logic [15:0]         idx_q, idx_d;      // index of the word being assembled
    logic [1:0]          sel_q, sel_d;      // byte position inside the word
    logic [23:0]         word_q, word_d;    // first three bytes of the current word
    logic [7:0]          chk_q, chk_d;      // running XOR of the stream
    logic [31:0]         wdata_q, wdata_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic                we_q, we_d;

    logic                accept;
    logic [15:0]         hdr_n;

    // Byte acceptance is only possible while a header, data or checksum byte is due.
    always_comb begin
        ByteReady = (state_q == S_HDR_HI) || (state_q == S_HDR_LO) ||
                    (state_q == S_DATA)   || (state_q == S_CHK);
    end

    assign accept       = ByteValid & ByteReady;
    assign hdr_n        = {cnt_q[15:8], ByteIn};
    assign WriteData    = wdata_q;
    assign WriteAddress = waddr_q;
    assign WriteEnable  = we_q;
    assign Done         = (state_q == S_DONE);
    assign Error        = (state_q == S_ERR);
    assign CoreHold     = (state_q != S_DONE);
    assign DbgState     = state_q;

    // Next-state and datapath updates; the write strobe defaults low so it is a single pulse.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sel_d   = sel_q;
        word_d  = word_q;
        chk_d   = chk_q;
        wdata_d = wdata_q;
        waddr_d = waddr_q;
        we_d    = 1'b0;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (Start) begin
                    state_d = S_HDR_HI;
                    cnt_d   = '0;
                    idx_d   = '0;
                    sel_d   = '0;
                    word_d  = '0;
                    chk_d   = '0;
                end
            end
            S_HDR_HI: begin
                if (accept) begin
                    cnt_d   = {ByteIn, 8'h00};
                    chk_d   = chk_q ^ ByteIn;
                    state_d = S_HDR_LO;
                end
            end
            S_HDR_LO: begin
                if (accept) begin
                    cnt_d = hdr_n;
                    chk_d = chk_q ^ ByteIn;
                    if (hdr_n == 16'd0) begin
                        state_d = S_CHK;
                    end else if ({1'b0, hdr_n} > MAX_W) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    chk_d  = chk_q ^ ByteIn;
                    word_d = {word_q[15:0], ByteIn};
                    sel_d  = sel_q + 2'd1;
                    if (sel_q == 2'd3) begin
                        we_d    = 1'b1;
                        wdata_d = {word_q, ByteIn};
                        waddr_d = BASE_ADDR + ADDR_W'({idx_q, 2'b00});
                        idx_d   = idx_q + 16'd1;
                        if (idx_q == cnt_q - 16'd1) begin
                            state_d = S_CHK;
                        end
                    end
                end
            end
            S_CHK: begin
                if (accept) begin
                    state_d = (ByteIn == chk_q) ? S_DONE : S_ERR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset drops any partially assembled word.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sel_q   <= '0;
            word_q  <= '0;
            chk_q   <= '0;
            wdata_q <= '0;
            waddr_q <= BASE_ADDR;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
            word_q  <= word_d;
            chk_q   <= chk_d;
            wdata_q <= wdata_d;
            waddr_q <= waddr_d;
            we_q    <= we_d;
        end
    end

endmodule
